// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII control codes and the receive-line states,
// used by the RX line controller, the TX path and the command decoder.
package uart_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_BS = 8'h08;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_HOLD    = 2'd1,
      ST_DISCARD = 2'd2
   } line_state_e;

endpackage

// File: rtl/uart_line_buf.sv
// Line buffer: DEPTH x 8 register file, synchronous write, combinational read.
module uart_line_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem_q [DEPTH];

   // NOTE: storage has no reset; the valid length lives in the controller,
   // and leaving the array unreset lets it map onto plain registers or LUT RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_line_ctrl.sv
// UART RX line assembler: collects bytes into a command line with BS, CR/LF,
// overflow and timeout handling. Define RX_LINE_CTRL_UPCASE_EN to fold a-z to A-Z.
module uart_rx_line_ctrl
   import uart_pkg::*;
#(
   parameter int MAX_LEN       = 16,
   parameter int LEN_W         = $clog2(MAX_LEN + 1),
   parameter int TIMEOUT_TICKS = 640
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [7:0]                 d_rx,
   input  logic                       vld_rx,
   output logic                       rdy_rx,
   output logic                       line_vld,
   output logic [LEN_W-1:0]           line_len,
   input  logic                       line_ack,
   input  logic [$clog2(MAX_LEN)-1:0] buf_raddr,
   output logic [7:0]                 buf_rdata,
   output logic                       err_ovf,
   output logic                       err_tmo
);

   localparam int                 AW        = $clog2(MAX_LEN);
   localparam int                 IDLE_W    = $clog2(TIMEOUT_TICKS);
   localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
   localparam logic [IDLE_W-1:0]  IDLE_ONE  = IDLE_W'(1);
   localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);

   line_state_e       state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  line_len_q, line_len_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              line_vld_q, line_vld_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_tmo_q, err_tmo_d;
   logic              vld_q;
   logic              accept, is_term, buf_we;
   logic [7:0]        wdata;

   // One byte per vld_rx assertion: only the rising edge of vld_rx is taken.
   assign accept  = vld_rx & ~vld_q & rdy_rx;
   assign is_term = (d_rx == ASCII_CR) || (d_rx == ASCII_LF);

`ifdef RX_LINE_CTRL_UPCASE_EN
   assign wdata = (d_rx >= 8'h61 && d_rx <= 8'h7A) ? d_rx - 8'h20 : d_rx;
`else
   assign wdata = d_rx;
`endif

   // NOTE: every output of this block gets a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idle_d     = idle_q;
      line_vld_d = line_vld_q;
      line_len_d = line_len_q;
      err_ovf_d  = 1'b0;
      err_tmo_d  = 1'b0;
      buf_we     = 1'b0;
      unique case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               idle_d = '0;
               if (is_term) begin
                  if (len_q != '0) begin
                     line_len_d = len_q;
                     line_vld_d = 1'b1;
                     state_d    = ST_HOLD;
                  end
               end else if (d_rx == ASCII_BS) begin
                  if (len_q != '0) len_d = len_q - LEN_ONE;
               end else if (len_q != LEN_MAX) begin
                  buf_we = 1'b1;
                  len_d  = len_q + LEN_ONE;
               end else begin
                  err_ovf_d = 1'b1;
                  len_d     = '0;
                  state_d   = ST_DISCARD;
               end
            end else if (len_q == '0) begin
               idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
               err_tmo_d = 1'b1;
               len_d     = '0;
               idle_d    = '0;
            end else begin
               idle_d = idle_q + IDLE_ONE;
            end
         end
         ST_HOLD: begin
            idle_d = '0;
            if (line_ack) begin
               line_vld_d = 1'b0;
               len_d      = '0;
               state_d    = ST_COLLECT;
            end
         end
         ST_DISCARD: begin
            // The idle counter doubles as a silent escape from discarding.
            if (accept) begin
               idle_d = '0;
               if (is_term) state_d = ST_COLLECT;
            end else if (idle_q == IDLE_LAST) begin
               idle_d  = '0;
               state_d = ST_COLLECT;
            end else begin
               idle_d = idle_q + IDLE_ONE;
            end
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value regardless of block ordering.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_COLLECT;
         len_q      <= '0;
         idle_q     <= '0;
         vld_q      <= 1'b0;
         line_vld_q <= 1'b0;
         line_len_q <= '0;
         err_ovf_q  <= 1'b0;
         err_tmo_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idle_q     <= idle_d;
         vld_q      <= vld_rx;
         line_vld_q <= line_vld_d;
         line_len_q <= line_len_d;
         err_ovf_q  <= err_ovf_d;
         err_tmo_q  <= err_tmo_d;
      end
   end

   uart_line_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_line_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (len_q[AW-1:0]),
      .wdata (wdata),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

   assign rdy_rx   = (state_q != ST_HOLD);
   assign line_vld = line_vld_q;
   assign line_len = line_len_q;
   assign err_ovf  = err_ovf_q;
   assign err_tmo  = err_tmo_q;

endmodule

// File: tb/tb_uart_rx_line_ctrl.sv
// Self-checking bench for uart_rx_line_ctrl: directed scenarios plus random
// byte streams checked against a queue-based line model.
`timescale 1ns/1ps
module tb_uart_rx_line_ctrl;

   localparam int MAX_LEN = 16;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int AW      = $clog2(MAX_LEN);
   localparam int TMO     = 640;

   logic             clk = 1'b0;
   logic             rstn;
   logic [7:0]       d_rx;
   logic             vld_rx;
   logic             rdy_rx;
   logic             line_vld;
   logic [LEN_W-1:0] line_len;
   logic             line_ack;
   logic [AW-1:0]    buf_raddr;
   logic [7:0]       buf_rdata;
   logic             err_ovf;
   logic             err_tmo;

   int n_checks = 0;
   int n_fail   = 0;
   int ovf_cnt  = 0;
   int tmo_cnt  = 0;

   // Observations from get_line.
   bit         obs_got;
   int         obs_len;
   logic [7:0] obs_bytes[$];
   logic       obs_rdy_hold, obs_rdy_after, obs_vld_after;

   // Reference model state.
   bit         m_discard;
   logic [7:0] m_line[$];
   int         exp_lens[$];
   logic [7:0] exp_data[$];
   int         exp_ovf;

   uart_rx_line_ctrl #(
      .MAX_LEN       (MAX_LEN),
      .LEN_W         (LEN_W),
      .TIMEOUT_TICKS (TMO)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .d_rx      (d_rx),
      .vld_rx    (vld_rx),
      .rdy_rx    (rdy_rx),
      .line_vld  (line_vld),
      .line_len  (line_len),
      .line_ack  (line_ack),
      .buf_raddr (buf_raddr),
      .buf_rdata (buf_rdata),
      .err_ovf   (err_ovf),
      .err_tmo   (err_tmo)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (err_ovf) ovf_cnt++;
      if (err_tmo) tmo_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef RX_LINE_CTRL_UPCASE_EN
      return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
      return b;
`endif
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      d_rx   = b;
      vld_rx = 1'b1;
      tick(1);
      vld_rx = 1'b0;
      tick(1);
   endtask

   // Waits (bounded) for a held line, reads every byte, then acknowledges.
   task automatic get_line();
      int n = 0;
      obs_got = 1'b0;
      obs_len = 0;
      obs_bytes.delete();
      while (!line_vld && n < 40) begin
         tick(1);
         n++;
      end
      if (!line_vld) return;
      obs_got      = 1'b1;
      obs_len      = int'(line_len);
      obs_rdy_hold = rdy_rx;
      for (int i = 0; i < obs_len && i < MAX_LEN; i++) begin
         buf_raddr = AW'(i);
         tick(1);
         obs_bytes.push_back(buf_rdata);
      end
      line_ack = 1'b1;
      tick(1);
      line_ack      = 1'b0;
      obs_rdy_after = rdy_rx;
      obs_vld_after = line_vld;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_discard) begin
         if (b == 8'h0D || b == 8'h0A) m_discard = 1'b0;
      end else if (b == 8'h0D || b == 8'h0A) begin
         if (m_line.size() > 0) begin
            exp_lens.push_back(m_line.size());
            foreach (m_line[i]) exp_data.push_back(m_line[i]);
            m_line.delete();
         end
      end else if (b == 8'h08) begin
         if (m_line.size() > 0) void'(m_line.pop_back());
      end else if (m_line.size() < MAX_LEN) begin
         m_line.push_back(fold(b));
      end else begin
         m_line.delete();
         m_discard = 1'b1;
         exp_ovf++;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; vld_rx = 1'b0; d_rx = 8'h00; line_ack = 1'b0; buf_raddr = '0;
      tick(3);
      n_checks++;
      if (rdy_rx !== 1'b1 || line_vld !== 1'b0 || line_len !== '0 ||
          err_ovf !== 1'b0 || err_tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b len=%0d ovf=%b tmo=%b, want 1 0 0 0 0",
                  rdy_rx, line_vld, line_len, err_ovf, err_tmo);
      end
      rstn = 1'b1;
      tick(2);
   endtask

   task automatic test_basic_line();
      logic [7:0] s[4] = '{8'h61, 8'h62, 8'h31, 8'h0D};
      foreach (s[i]) send_byte(s[i]);
      get_line();
      n_checks++;
      if (obs_got !== 1'b1 || obs_len != 3) begin
         n_fail++;
         $display("FAIL basic_len: got vld=%b len=%0d, want vld=1 len=3", obs_got, obs_len);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= obs_bytes.size() || obs_bytes[i] !== fold(s[i])) begin
            n_fail++;
            $display("FAIL basic_byte%0d: got %h want %h", i,
                     (i < obs_bytes.size()) ? obs_bytes[i] : 8'hxx, fold(s[i]));
         end
      end
      n_checks++;
      if (obs_rdy_hold !== 1'b0 || obs_rdy_after !== 1'b1 || obs_vld_after !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_handshake: got rdy_hold=%b rdy_after=%b vld_after=%b, want 0 1 0",
                  obs_rdy_hold, obs_rdy_after, obs_vld_after);
      end
   endtask

   task automatic test_crlf();
      send_byte(8'h41); send_byte(8'h42); send_byte(8'h0D);
      get_line();
      n_checks++;
      if (obs_got !== 1'b1 || obs_len != 2 || obs_bytes.size() != 2 ||
          obs_bytes[0] !== 8'h41 || obs_bytes[1] !== 8'h42) begin
         n_fail++;
         $display("FAIL crlf_first: got vld=%b len=%0d, want vld=1 len=2 data 41 42", obs_got, obs_len);
      end
      send_byte(8'h0A);
      tick(4);
      n_checks++;
      if (line_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL crlf_empty_line: got line_vld=%b want 0", line_vld);
      end
      send_byte(8'h43); send_byte(8'h0D);
      get_line();
      n_checks++;
      if (obs_got !== 1'b1 || obs_len != 1 || obs_bytes.size() != 1 || obs_bytes[0] !== 8'h43) begin
         n_fail++;
         $display("FAIL crlf_second: got vld=%b len=%0d, want vld=1 len=1 data 43", obs_got, obs_len);
      end
   endtask

   task automatic test_backspace();
      logic [7:0] s[7] = '{8'h58, 8'h59, 8'h08, 8'h08, 8'h08, 8'h5A, 8'h0D};
      foreach (s[i]) send_byte(s[i]);
      get_line();
      n_checks++;
      if (obs_got !== 1'b1 || obs_len != 1 || obs_bytes.size() != 1 || obs_bytes[0] !== 8'h5A) begin
         n_fail++;
         $display("FAIL backspace: got vld=%b len=%0d byte0=%h, want vld=1 len=1 byte0=5a",
                  obs_got, obs_len, (obs_bytes.size() > 0) ? obs_bytes[0] : 8'hxx);
      end
   endtask

   task automatic test_overflow();
      int base = ovf_cnt;
      for (int i = 0; i < MAX_LEN; i++) send_byte(8'h41 + 8'(i));
      n_checks++;
      if (ovf_cnt != base) begin
         n_fail++;
         $display("FAIL ovf_early: got %0d pulses after %0d bytes, want 0", ovf_cnt - base, MAX_LEN);
      end
      send_byte(8'h51);
      tick(2);
      n_checks++;
      if (ovf_cnt - base != 1) begin
         n_fail++;
         $display("FAIL ovf_pulse: got %0d pulses want 1", ovf_cnt - base);
      end
      send_byte(8'h51); send_byte(8'h51); send_byte(8'h0D);
      tick(4);
      n_checks++;
      if (line_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_discard: got line_vld=%b want 0", line_vld);
      end
      send_byte(8'h4F); send_byte(8'h4B); send_byte(8'h0D);
      get_line();
      n_checks++;
      if (obs_got !== 1'b1 || obs_len != 2 || obs_bytes.size() != 2 ||
          obs_bytes[0] !== 8'h4F || obs_bytes[1] !== 8'h4B) begin
         n_fail++;
         $display("FAIL ovf_recover: got vld=%b len=%0d, want vld=1 len=2 data 4f 4b", obs_got, obs_len);
      end
      // Discard ended by idle time instead of a terminator: silent, no err_tmo.
      base = tmo_cnt;
      for (int i = 0; i <= MAX_LEN; i++) send_byte(8'h30);
      tick(TMO + 10);
      send_byte(8'h48); send_byte(8'h49); send_byte(8'h0D);
      get_line();
      n_checks++;
      if (tmo_cnt != base || obs_got !== 1'b1 || obs_len != 2) begin
         n_fail++;
         $display("FAIL discard_timeout: got tmo_pulses=%0d vld=%b len=%0d, want 0 1 2",
                  tmo_cnt - base, obs_got, obs_len);
      end
   endtask

   task automatic test_timeout();
      int base  = tmo_cnt;
      int first = -1;
      send_byte(8'h41);
      // Accept edge is cycle 0; send_byte returns just after cycle 1.
      for (int c = 2; c <= 1000 && first < 0; c++) begin
         tick(1);
         if (err_tmo) first = c;
      end
      tick(5);
      n_checks++;
      if (first != TMO) begin
         n_fail++;
         $display("FAIL tmo_cycle: got err_tmo at cycle %0d want %0d", first, TMO);
      end
      n_checks++;
      if (tmo_cnt - base != 1) begin
         n_fail++;
         $display("FAIL tmo_pulse_count: got %0d want 1", tmo_cnt - base);
      end
      send_byte(8'h42); send_byte(8'h0D);
      get_line();
      n_checks++;
      if (obs_got !== 1'b1 || obs_len != 1 || obs_bytes.size() != 1 || obs_bytes[0] !== 8'h42) begin
         n_fail++;
         $display("FAIL tmo_recover: got vld=%b len=%0d, want vld=1 len=1 data 42", obs_got, obs_len);
      end
   endtask

   task automatic test_held_valid();
      d_rx   = 8'h41;
      vld_rx = 1'b1;
      tick(50);
      vld_rx = 1'b0;
      tick(1);
      send_byte(8'h0D);
      get_line();
      n_checks++;
      if (obs_got !== 1'b1 || obs_len != 1 || obs_bytes.size() != 1 || obs_bytes[0] !== 8'h41) begin
         n_fail++;
         $display("FAIL held_valid: got vld=%b len=%0d, want vld=1 len=1 data 41", obs_got, obs_len);
      end
   endtask

   task automatic test_reset_in_hold();
      int n = 0;
      send_byte(8'h41); send_byte(8'h0D);
      while (!line_vld && n < 40) begin
         tick(1);
         n++;
      end
      n_checks++;
      if (line_vld !== 1'b1 || rdy_rx !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_entry: got line_vld=%b rdy=%b, want 1 0", line_vld, rdy_rx);
      end
      rstn = 1'b0;
      #1;
      n_checks++;
      if (line_vld !== 1'b0 || rdy_rx !== 1'b1 || line_len !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got line_vld=%b rdy=%b len=%0d, want 0 1 0",
                  line_vld, rdy_rx, line_len);
      end
      tick(2);
      rstn = 1'b1;
      tick(2);
      send_byte(8'h5A); send_byte(8'h0D);
      get_line();
      n_checks++;
      if (obs_got !== 1'b1 || obs_len != 1 || obs_bytes.size() != 1 || obs_bytes[0] !== 8'h5A) begin
         n_fail++;
         $display("FAIL after_reset: got vld=%b len=%0d, want vld=1 len=1 data 5a", obs_got, obs_len);
      end
   endtask

   task automatic test_random();
      int base = ovf_cnt;
      m_discard = 1'b0;
      m_line.delete();
      exp_lens.delete();
      exp_data.delete();
      exp_ovf = 0;
      for (int k = 0; k < 400; k++) begin
         logic [7:0] b;
         int r = $urandom_range(0, 99);
         if (r < 10)      b = 8'h0D;
         else if (r < 15) b = 8'h0A;
         else if (r < 25) b = 8'h08;
         else             b = 8'($urandom_range(8'h20, 8'h7E));
         send_byte(b);
         model_byte(b);
         if (exp_lens.size() > 0) begin
            int el = exp_lens.pop_front();
            get_line();
            n_checks++;
            if (obs_got !== 1'b1 || obs_len != el) begin
               n_fail++;
               $display("FAIL rand_len (byte %0d): got vld=%b len=%0d want vld=1 len=%0d",
                        k, obs_got, obs_len, el);
            end
            for (int i = 0; i < el; i++) begin
               logic [7:0] e = exp_data.pop_front();
               n_checks++;
               if (i >= obs_bytes.size() || obs_bytes[i] !== e) begin
                  n_fail++;
                  $display("FAIL rand_byte%0d (byte %0d): got %h want %h", i, k,
                           (i < obs_bytes.size()) ? obs_bytes[i] : 8'hxx, e);
               end
            end
         end
      end
      tick(2);
      n_checks++;
      if (ovf_cnt - base != exp_ovf) begin
         n_fail++;
         $display("FAIL rand_ovf_count: got %0d want %0d", ovf_cnt - base, exp_ovf);
      end
   endtask

   initial begin
      test_reset();
      test_basic_line();
      test_crlf();
      test_backspace();
      test_overflow();
      test_timeout();
      test_held_valid();
      test_reset_in_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
